// File: rtl/tank_render_ctrl.sv
// Tank render sequencer: erases the old tank footprint, then draws the tank at its new pose.
// Optional macro TANK_ERASE_EN enables the ERASE phase; without it every request goes straight to DRAW.
module tank_render_ctrl #(
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [6:0] TIMEOUT   = 7'd64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move_req,
  input  logic [7:0] new_xpos,
  input  logic [6:0] new_ypos,
  input  logic [1:0] new_dir,
  input  logic [2:0] tank_colour,
  input  logic       draw_finish,
  output logic [7:0] xpos,
  output logic [6:0] ypos,
  output logic [1:0] direction,
  output logic       counter_enable,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic       error
);

`ifdef TANK_ERASE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t     state;
  logic [7:0] old_x, cur_x, pend_x;
  logic [6:0] old_y, cur_y, pend_y;
  logic [1:0] old_dir, cur_dir, pend_dir;
  logic [2:0] cur_colour, pend_colour;
  logic       pend_valid;
  logic [6:0] cyc_cnt;
`ifdef TANK_ERASE_EN
  logic       drawn;
`endif

  // A live request always supersedes an older buffered one.
  logic       start;
  logic [7:0] src_x;
  logic [6:0] src_y;
  logic [1:0] src_dir;
  logic [2:0] src_colour;
  logic       timed_out;

  assign start      = move_req || pend_valid;
  assign src_x      = move_req ? new_xpos    : pend_x;
  assign src_y      = move_req ? new_ypos    : pend_y;
  assign src_dir    = move_req ? new_dir     : pend_dir;
  assign src_colour = move_req ? tank_colour : pend_colour;
  assign timed_out  = (cyc_cnt == TIMEOUT - 7'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      old_x          <= '0;
      old_y          <= '0;
      old_dir        <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      cur_dir        <= '0;
      cur_colour     <= '0;
      pend_x         <= '0;
      pend_y         <= '0;
      pend_dir       <= '0;
      pend_colour    <= '0;
      pend_valid     <= 1'b0;
      cyc_cnt        <= '0;
`ifdef TANK_ERASE_EN
      drawn          <= 1'b0;
`endif
      xpos           <= '0;
      ypos           <= '0;
      direction      <= '0;
      colour         <= '0;
      plot           <= 1'b0;
      counter_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            cur_x          <= src_x;
            cur_y          <= src_y;
            cur_dir        <= src_dir;
            cur_colour     <= src_colour;
            pend_valid     <= 1'b0;
            cyc_cnt        <= '0;
            busy           <= 1'b1;
            plot           <= 1'b1;
            counter_enable <= 1'b1;
`ifdef TANK_ERASE_EN
            if (drawn) begin
              state     <= ERASE;
              xpos      <= old_x;
              ypos      <= old_y;
              direction <= old_dir;
              colour    <= BG_COLOUR;
            end else
`endif
            begin
              state     <= DRAW;
              xpos      <= src_x;
              ypos      <= src_y;
              direction <= src_dir;
              colour    <= src_colour;
            end
          end else begin
            state          <= IDLE;
            busy           <= 1'b0;
            plot           <= 1'b0;
            counter_enable <= 1'b0;
            xpos           <= old_x;
            ypos           <= old_y;
            direction      <= old_dir;
            colour         <= BG_COLOUR;
          end
        end

`ifdef TANK_ERASE_EN
        ERASE,
`endif
        DRAW: begin
          if (move_req) begin
            pend_x      <= new_xpos;
            pend_y      <= new_ypos;
            pend_dir    <= new_dir;
            pend_colour <= tank_colour;
            pend_valid  <= 1'b1;
          end
          if (draw_finish) begin
            if (state == DRAW) begin
              state          <= DONE;
              old_x          <= cur_x;
              old_y          <= cur_y;
              old_dir        <= cur_dir;
`ifdef TANK_ERASE_EN
              drawn          <= 1'b1;
`endif
              plot           <= 1'b0;
              counter_enable <= 1'b0;
              done           <= 1'b1;
            end
`ifdef TANK_ERASE_EN
            else begin
              state     <= DRAW;
              cyc_cnt   <= '0;
              xpos      <= cur_x;
              ypos      <= cur_y;
              direction <= cur_dir;
              colour    <= cur_colour;
            end
`endif
          end else if (timed_out) begin
            // Abort leaves the old pose untouched so the next erase hits the last good footprint.
            state          <= IDLE;
            error          <= 1'b1;
            plot           <= 1'b0;
            counter_enable <= 1'b0;
            busy           <= 1'b0;
            xpos           <= old_x;
            ypos           <= old_y;
            direction      <= old_dir;
            colour         <= BG_COLOUR;
          end else begin
            cyc_cnt <= cyc_cnt + 7'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_render_ctrl.sv
// Directed self-checking bench for tank_render_ctrl with a 60-pixel sprite counter model.
// Works in both builds; erase expectations scale with TANK_ERASE_EN.
module tb_tank_render_ctrl;

`ifdef TANK_ERASE_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       move_req = 1'b0;
  logic [7:0] new_xpos = '0;
  logic [6:0] new_ypos = '0;
  logic [1:0] new_dir = '0;
  logic [2:0] tank_colour = '0;
  logic       draw_finish;
  logic [7:0] xpos;
  logic [6:0] ypos;
  logic [1:0] direction;
  logic       counter_enable, plot, busy, done, error;
  logic [2:0] colour;

  int n_checks = 0;
  int n_fail   = 0;
  logic suppress = 1'b0;
  logic [5:0] sprite_cnt;

  int bg_hist [256];
  int tk_hist [256];
  int tk_dir  [4];
  int bg_total, done_cnt;

  tank_render_ctrl #(.BG_COLOUR(BG), .TIMEOUT(7'd64)) dut (
    .clk(clk), .resetn(resetn), .move_req(move_req),
    .new_xpos(new_xpos), .new_ypos(new_ypos), .new_dir(new_dir),
    .tank_colour(tank_colour), .draw_finish(draw_finish),
    .xpos(xpos), .ypos(ypos), .direction(direction),
    .counter_enable(counter_enable), .plot(plot), .colour(colour),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Sprite counter: 60 enabled cycles per phase, finish strobe on pixel 59.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)               sprite_cnt <= '0;
    else if (!counter_enable)  sprite_cnt <= '0;
    else if (sprite_cnt == 59) sprite_cnt <= '0;
    else                       sprite_cnt <= sprite_cnt + 6'd1;
  end
  assign draw_finish = counter_enable && (sprite_cnt == 59) && !(suppress && colour != BG);

  always @(negedge clk) begin
    if (resetn && plot) begin
      if (colour == BG) begin
        bg_hist[xpos] = bg_hist[xpos] + 1;
        bg_total = bg_total + 1;
      end else begin
        tk_hist[xpos] = tk_hist[xpos] + 1;
        tk_dir[direction] = tk_dir[direction] + 1;
      end
    end
    if (resetn && done) done_cnt = done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearHist();
    for (int i = 0; i < 256; i++) begin
      bg_hist[i] = 0;
      tk_hist[i] = 0;
    end
    for (int i = 0; i < 4; i++) tk_dir[i] = 0;
    bg_total = 0;
    done_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y,
                               input logic [1:0] d, input logic [2:0] c);
    @(negedge clk);
    new_xpos = x; new_ypos = y; new_dir = d; tank_colour = c;
    move_req = 1'b1;
    @(negedge clk);
    move_req = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_wait_expired", 0, 1);
  endtask

  task automatic waitTankPlot(input logic [7:0] x);
    int n = 0;
    while (!(plot && colour != BG && xpos == x) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("draw_wait_expired", 0, 1);
  endtask

  initial begin
    clearHist();
    repeat (3) @(negedge clk);
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_ce", counter_enable, 0);
    checkOutput("rst_pose", {xpos, ypos, direction, colour}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // First request after reset skips erase.
    applyStimulus(8'd20, 7'd30, 2'd0, 3'b100);
    waitIdle();
    checkOutput("r1_bg_plots", bg_total, 0);
    checkOutput("r1_tank_plots", tk_hist[20], 60);
    checkOutput("r1_done_pulses", done_cnt, 1);
    checkOutput("r1_busy", busy, 0);
    checkOutput("r1_plot_idle", plot, 0);
    checkOutput("r1_idle_pose", {xpos, ypos, direction}, {8'd20, 7'd30, 2'd0});

    clearHist();
    applyStimulus(8'd21, 7'd30, 2'd3, 3'b010);
    waitIdle();
    checkOutput("r2_erase_old_x", bg_hist[20], 60 * E);
    checkOutput("r2_bg_total", bg_total, 60 * E);
    checkOutput("r2_tank_plots", tk_hist[21], 60);
    checkOutput("r2_tank_dir3", tk_dir[3], 60);
    checkOutput("r2_done_pulses", done_cnt, 1);

    // Two requests during DRAW: only the later one survives.
    clearHist();
    applyStimulus(8'd30, 7'd30, 2'd1, 3'b001);
    waitTankPlot(8'd30);
    @(negedge clk);
    new_xpos = 8'd40; move_req = 1'b1;
    @(negedge clk);
    new_xpos = 8'd50;
    @(negedge clk);
    move_req = 1'b0;
    waitIdle();
    checkOutput("r3_first_draw", tk_hist[30], 60);
    checkOutput("r3_overwritten", tk_hist[40], 0);
    checkOutput("r3_last_draw", tk_hist[50], 60);
    checkOutput("r3_erase_prev", bg_hist[21], 60 * E);
    checkOutput("r3_erase_just_drawn", bg_hist[30], 60 * E);
    checkOutput("r3_done_pulses", done_cnt, 2);
    checkOutput("r3_idle_x", xpos, 50);

    // Draw phase that never finishes aborts after 64 cycles.
    clearHist();
    suppress = 1'b1;
    applyStimulus(8'd60, 7'd10, 2'd2, 3'b101);
    waitIdle();
    suppress = 1'b0;
    checkOutput("to_error", error, 1);
    checkOutput("to_plot", plot, 0);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_draw_cycles", tk_hist[60], 64);
    checkOutput("to_no_done", done_cnt, 0);
    checkOutput("to_old_pose", {xpos, ypos, direction}, {8'd50, 7'd30, 2'd1});

    clearHist();
    applyStimulus(8'd70, 7'd20, 2'd0, 3'b110);
    waitIdle();
    checkOutput("post_to_erase_x50", bg_hist[50], 60 * E);
    checkOutput("post_to_draw", tk_hist[70], 60);
    checkOutput("post_to_error_sticky", error, 1);

    // Reset in the middle of a draw.
    clearHist();
    applyStimulus(8'd80, 7'd5, 2'd1, 3'b011);
    waitTankPlot(8'd80);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("mid_rst_plot", plot, 0);
    checkOutput("mid_rst_ce", counter_enable, 0);
    checkOutput("mid_rst_status", {busy, done, error}, 0);
    checkOutput("mid_rst_pose", {xpos, ypos, direction, colour}, 0);
    @(negedge clk);
    resetn = 1'b1;
    clearHist();
    applyStimulus(8'd90, 7'd40, 2'd2, 3'b100);
    waitIdle();
    checkOutput("after_rst_no_erase", bg_total, 0);
    checkOutput("after_rst_draw", tk_hist[90], 60);
    checkOutput("after_rst_done", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
